fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the MIPS core.
- Owns the program counter and drives the address of the combinational, byte-addressable instruction ROM (16-bit address, 32-bit little-endian word read, same cycle).
- Registers the returned word into the IF/ID pipeline register for decode.
- Honours stall, flush and branch/jump redirect requests from the hazard unit and the decode stage.

Parameters:
- ADDR_W, 16, PC / instruction-memory address width in bits.
- RESET_PC, 16'h0000, PC value loaded on reset; must be word-aligned.
- CNT_W, 32, width of the fetched-instruction counter.

Ports:
- i_CLK  in  1  clock; all state updates on the rising edge.
- i_RST  in  1  reset, synchronous, active-high.
- i_STALL  in  1  hold PC and IF/ID contents this cycle.
- i_FLUSH  in  1  replace IF/ID contents with a bubble next edge.
- i_REDIRECT  in  1  taken branch/jump; load PC from i_REDIRECT_PC.
- i_REDIRECT_PC  in  ADDR_W  redirect target byte address.
- o_IMEM_A  out  ADDR_W  address to instruction memory; equals current PC.
- i_IMEM_RD  in  32  instruction word returned combinationally for o_IMEM_A.
- o_IFID_INSTR  out  32  registered instruction to decode.
- o_IFID_PC  out  ADDR_W  PC of o_IFID_INSTR.
- o_IFID_PC4  out  ADDR_W  o_IFID_PC + 4, modulo 2^ADDR_W.
- o_IFID_VALID  out  1  IF/ID holds a real instruction (0 = bubble).
- o_MISALIGN  out  1  one-cycle pulse: a redirect target had bits [1:0] != 0.
- o_FETCH_CNT  out  CNT_W  count of instructions accepted into IF/ID.

Behaviour:
- Reset (i_RST=1 at edge): PC=RESET_PC; o_IFID_INSTR=NOP (32'h0); o_IFID_PC=0; o_IFID_PC4=0; o_IFID_VALID=0; o_MISALIGN=0; o_FETCH_CNT=0. Reset overrides every other input.
- Reset mid-operation: same as above; an in-flight redirect or stall is discarded.
- o_IMEM_A = PC combinationally. Fetch latency: the word at PC appears on o_IFID_INSTR one edge later.
- PC next-state priority: reset > redirect > stall > increment.
  - Redirect: PC <= {i_REDIRECT_PC[ADDR_W-1:2], 2'b00}. o_MISALIGN <= |i_REDIRECT_PC[1:0]; otherwise o_MISALIGN <= 0.
  - Stall (no redirect): PC holds.
  - Otherwise: PC <= PC + 4, wrapping 16'hFFFC -> 16'h0000 with no flag.
- IF/ID next-state priority: reset > flush > stall > load.
  - Flush: INSTR=NOP, VALID=0, PC and PC4 cleared to 0.
  - Stall: all IF/ID fields hold.
  - Load: INSTR=i_IMEM_RD, PC=current PC, PC4=PC+4, VALID=1.
- i_REDIRECT and i_FLUSH are independent; the decode stage asserts both for a taken branch. Redirect without flush lets the delay-slot word at the current PC enter IF/ID.
- i_STALL with i_REDIRECT: PC takes the redirect. IF/ID holds unless i_FLUSH is also asserted.
- o_FETCH_CNT increments by 1 on every load edge (not flush, stall or reset). It wraps modulo 2^CNT_W.
- No combinational path from i_IMEM_RD to any output.

Decomposition:
- Package mips_pkg holds:
  - localparam ADDR_W=16 and INSTR_W=32.
  - localparam NOP=32'h0000_0000.
  - typedef instr_t (logic [31:0]) and addr_t (logic [15:0]).
  - packed struct ifid_t {instr, pc, pc4, valid}, shared with decode.
- One sub-module, pc_reg: PC register plus next-PC mux and misalignment detect. fetch_stage instantiates pc_reg and holds the IF/ID register and counter.

Test Plan:
- Reset, then 4 free-running cycles, ROM words 0x11,0x22,0x33,0x44 at 0,4,8,12 -> o_IMEM_A sequence 0,4,8,12; IF/ID shows 0x11 (PC=0, PC4=4, VALID=1) one edge after reset release; o_FETCH_CNT=4.
- i_STALL=1 for 2 cycles with PC=8 -> o_IMEM_A stays 8; o_IFID_INSTR and PC hold; o_FETCH_CNT unchanged. Release -> PC advances to 12.
- i_REDIRECT=1, i_FLUSH=1, i_REDIRECT_PC=16'h0040 at PC=12 -> next cycle o_IMEM_A=0x0040 and o_IFID_VALID=0 with INSTR=0. Following cycle IF/ID holds word at 0x40 with PC4=0x44.
- i_REDIRECT_PC=16'h0042 -> PC=0x0040; o_MISALIGN high for exactly one cycle.
- Force PC=16'hFFFC via redirect, run 2 cycles -> o_IMEM_A goes 0xFFFC then 0x0000; IF/ID PC4 for 0xFFFC reads 0x0000.
- i_STALL=1 with i_REDIRECT=1 (to 0x80) and no flush -> PC=0x80 and IF/ID unchanged. Separately, assert i_RST while stalled -> all outputs at reset values next edge.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core pipeline.
// The IF/ID record is defined here so that fetch and decode use the same layout.
package mips_pkg;

    localparam int ADDR_W  = 16;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP = 32'h0000_0000;

    typedef logic [INSTR_W-1:0] instr_t;
    typedef logic [ADDR_W-1:0]  addr_t;

    typedef struct packed {
        instr_t instr;
        addr_t  pc;
        addr_t  pc4;
        logic   valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instr: NOP, pc: '0, pc4: '0, valid: 1'b0};

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC selection (redirect > stall > +4) and a
// one-cycle flag for redirect targets that are not word-aligned.
module pc_reg #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              misalign
);

    logic [ADDR_W-1:0] pc_d, pc_q;
    logic              misalign_d, misalign_q;

    // NOTE: every output of a combinational block gets a default first so no path infers a latch.
    always_comb begin
        pc_d       = pc_q + ADDR_W'(4);
        misalign_d = 1'b0;
        if (redirect) begin
            pc_d       = {redirect_pc[ADDR_W-1:2], 2'b00};
            misalign_d = |redirect_pc[1:0];
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc       = pc_q;
    assign misalign = misalign_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the ROM address from the PC, registers the
// returned word into IF/ID, and counts instructions accepted into IF/ID.
module fetch_stage #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter int                CNT_W    = 32
) (
    input  logic              i_CLK,
    input  logic              i_RST,
    input  logic              i_STALL,
    input  logic              i_FLUSH,
    input  logic              i_REDIRECT,
    input  logic [ADDR_W-1:0] i_REDIRECT_PC,
    output logic [ADDR_W-1:0] o_IMEM_A,
    input  logic [31:0]       i_IMEM_RD,
    output logic [31:0]       o_IFID_INSTR,
    output logic [ADDR_W-1:0] o_IFID_PC,
    output logic [ADDR_W-1:0] o_IFID_PC4,
    output logic              o_IFID_VALID,
    output logic              o_MISALIGN,
    output logic [CNT_W-1:0]  o_FETCH_CNT
);

    import mips_pkg::*;

    logic [ADDR_W-1:0] pc;
    ifid_t             ifid_d, ifid_q;
    logic [CNT_W-1:0]  fetch_cnt_d, fetch_cnt_q;
    logic              load;

    pc_reg #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk         (i_CLK),
        .rst         (i_RST),
        .stall       (i_STALL),
        .redirect    (i_REDIRECT),
        .redirect_pc (i_REDIRECT_PC),
        .pc          (pc),
        .misalign    (o_MISALIGN)
    );

    assign o_IMEM_A = pc;

    // Flush wins over stall so a taken branch squashes the word even while stalled.
    assign load = !i_FLUSH && !i_STALL;

    always_comb begin
        ifid_d      = ifid_q;
        fetch_cnt_d = fetch_cnt_q;
        if (i_FLUSH) begin
            ifid_d = IFID_BUBBLE;
        end else if (load) begin
            ifid_d.instr = i_IMEM_RD;
            ifid_d.pc    = pc;
            ifid_d.pc4   = pc + ADDR_W'(4);
            ifid_d.valid = 1'b1;
            fetch_cnt_d  = fetch_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge i_CLK) begin
        if (i_RST) begin
            ifid_q      <= IFID_BUBBLE;
            fetch_cnt_q <= '0;
        end else begin
            ifid_q      <= ifid_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign o_IFID_INSTR = ifid_q.instr;
    assign o_IFID_PC    = ifid_q.pc;
    assign o_IFID_PC4   = ifid_q.pc4;
    assign o_IFID_VALID = ifid_q.valid;
    assign o_FETCH_CNT  = fetch_cnt_q;

endmodule
